// File: rtl/alu_b_pkg.sv
// alu_b_pkg: shared opcode constants and default widths for the ALU B-operand path
package alu_b_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W = 6;
  localparam logic [5:0] IROP = 6'h00;
  localparam logic [5:0] IJ = 6'h02;
  localparam logic [5:0] IADDI = 6'h08;
  localparam logic [5:0] IORI = 6'h0D;
  localparam logic [5:0] ILW = 6'h23;
  localparam logic [5:0] ISW = 6'h2B;
endpackage

// File: rtl/alu_b_sel.sv
// alu_b_sel: combinational B-operand select and valid decode from the execute opcode
module alu_b_sel
  import alu_b_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OPW = OP_W
) (
  input  logic [OPW-1:0]   E_op,
  input  logic [WIDTH-1:0] E_valB,
  output logic [WIDTH-1:0] nextB,
  output logic             nextValid
);
  // case (not ==) so an X/Z opcode falls through to the zero/invalid default
  always_comb begin
    nextB = '0;
    nextValid = 1'b0;
    case (E_op)
      OPW'(IROP), OPW'(IADDI), OPW'(IORI), OPW'(ILW), OPW'(ISW): begin
        nextB = E_valB;
        nextValid = 1'b1;
      end
      OPW'(IJ): nextValid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_b.sv
// alu_b: registered ALU operand B with valid flag, stall hold and synchronous reset
module alu_b
  import alu_b_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OPW = OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   E_op,
  input  logic [WIDTH-1:0] E_valB,
  input  logic             stall,
  output logic [WIDTH-1:0] e_aluB,
  output logic             e_aluB_valid
);
  logic [WIDTH-1:0] nextB;
  logic nextValid;
  alu_b_sel #(.WIDTH(WIDTH), .OPW(OPW)) sel (
    .E_op(E_op),
    .E_valB(E_valB),
    .nextB(nextB),
    .nextValid(nextValid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      e_aluB <= '0;
      e_aluB_valid <= 1'b0;
    end else if (!stall) begin
      e_aluB <= nextB;
      e_aluB_valid <= nextValid;
    end
  end
endmodule

// File: tb/tb_alu_b.sv
// tb_alu_b: directed vectors with literal expectations plus a per-cycle model comparison
module tb_alu_b;
  logic clk, rst, stall;
  logic [5:0] E_op;
  logic [31:0] E_valB;
  logic [31:0] e_aluB;
  logic e_aluB_valid;
  int errors = 0;
  int checks = 0;
  logic armed = 1'b0;
  logic [31:0] mB = '0;
  logic mV = 1'b0;
  logic [5:0] recog[6] = '{6'h00, 6'h02, 6'h08, 6'h0D, 6'h23, 6'h2B};

  alu_b dut (
    .clk(clk),
    .rst(rst),
    .E_op(E_op),
    .E_valB(E_valB),
    .stall(stall),
    .e_aluB(e_aluB),
    .e_aluB_valid(e_aluB_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic isKnown(input logic [5:0] op);
    foreach (recog[i]) if (recog[i] === op) return 1'b1;
    return 1'b0;
  endfunction

  // Model: a recognised opcode forwards B, except a jump which carries no B operand
  always @(posedge clk) begin
    if (rst) begin
      mB <= '0;
      mV <= 1'b0;
      armed <= 1'b1;
    end else if (!stall) begin
      mV <= isKnown(E_op);
      mB <= (isKnown(E_op) && E_op !== 6'h02) ? E_valB : 32'd0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (e_aluB !== mB || e_aluB_valid !== mV) begin
        errors++;
        $display("FAIL model t=%0t: got B=%h v=%b, want B=%h v=%b", $time, e_aluB, e_aluB_valid, mB, mV);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [5:0] o, input logic [31:0] v);
    @(negedge clk);
    rst = r;
    stall = s;
    E_op = o;
    E_valB = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] b, input logic vl);
    checks++;
    if (e_aluB !== b || e_aluB_valid !== vl) begin
      errors++;
      $display("FAIL %s: got B=%h v=%b, want B=%h v=%b", name, e_aluB, e_aluB_valid, b, vl);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    E_op = 6'h00;
    E_valB = '0;
    step(1, 0, 6'h00, 32'd0);       chk("reset", 32'd0, 0);
    step(0, 0, 6'h00, 32'd35);      chk("irop", 32'd35, 1);
    step(0, 0, 6'h02, 32'd77);      chk("ij", 32'd0, 1);
    step(0, 0, 6'h0D, 32'd77);      chk("iori", 32'd77, 1);
    step(0, 0, 6'h2B, 32'd88);      chk("isw", 32'd88, 1);
    step(0, 0, 6'h23, 32'd88);      chk("ilw", 32'd88, 1);
    step(0, 0, 6'h02, 32'd88);      chk("ij_b2b", 32'd0, 1);
    step(0, 0, 6'h3F, 32'hFFFFFFFF); chk("unrec_3f", 32'd0, 0);
    step(0, 0, 6'h01, 32'h12345678); chk("unrec_01", 32'd0, 0);
    step(0, 0, 6'h22, 32'h12345678); chk("unrec_22", 32'd0, 0);
    step(0, 0, 6'h08, 32'hDEADBEEF); chk("iaddi", 32'hDEADBEEF, 1);
    step(0, 1, 6'h3F, 32'd1);       chk("hold1", 32'hDEADBEEF, 1);
    step(0, 1, 6'h00, 32'd5);       chk("hold2", 32'hDEADBEEF, 1);
    step(0, 1, 6'h02, 32'd9);       chk("hold3", 32'hDEADBEEF, 1);
    step(1, 1, 6'h00, 32'd123);     chk("rst_stall", 32'd0, 0);
    step(0, 0, 6'h00, 32'h11);      chk("pre_rst", 32'h11, 1);
    step(1, 0, 6'h00, 32'h22);      chk("mid_rst", 32'd0, 0);
    step(0, 0, 6'h2B, 32'h33);      chk("post_rst", 32'h33, 1);
    step(0, 0, 6'h00, 32'h80000001); chk("msb_pass", 32'h80000001, 1);
    for (int i = 0; i < 60; i++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 2) == 0) ? 6'($urandom) : recog[$urandom_range(0, 5)];
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), o, $urandom);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_b.md
ALU_B -- requirements
Module: alu_b

Interface
REQ-001 Parameter WIDTH, default 32, operand/result data width in bits.
REQ-002 Parameter OPW, default 6, opcode width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port E_op  input  OPW  execute-stage instruction opcode.
REQ-007 Port E_valB  input  WIDTH  execute-stage B value: register rt, or the already-extended immediate.
REQ-008 Port stall  input  1  hold request; when high, the output register keeps its value.
REQ-009 Port e_aluB  output  WIDTH  registered ALU operand B.
REQ-010 Port e_aluB_valid  output  1  high when e_aluB holds a value produced by a recognised opcode.

Function
REQ-011 Next-value select SHALL be combinational from E_op and E_valB.
- IROP, IADDI, IORI, ILW, ISW -> E_valB.
- IJ -> all zeros.
- any other opcode -> all zeros.
REQ-012 Recognised opcodes (IROP, IJ, IADDI, IORI, ILW, ISW) SHALL set next valid = 1; unrecognised SHALL set next valid = 0.
REQ-013 On each rising clk with rst=0 and stall=0, e_aluB and e_aluB_valid SHALL load the selected values; latency is exactly one cycle.
REQ-014 With stall=1 and rst=0, both outputs SHALL hold their previous values.
REQ-015 The value SHALL pass through unmodified: no sign/zero extension, no arithmetic, full WIDTH bits.
REQ-016 Opcode compare SHALL be exact on all OPW bits; X/Z opcode bits SHALL select zero/invalid.
REQ-017 Back-to-back opcode changes on consecutive cycles SHALL each appear on the output one cycle later, with no bubbles.

Reset
REQ-018 While rst=1 at a rising clk, e_aluB SHALL become 0 and e_aluB_valid SHALL become 0, regardless of stall.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight value; the first post-reset output SHALL reflect the inputs sampled on the first clock with rst=0.

Structure
REQ-020 Opcode constants SHALL live in the shared package.
- IROP = 6'h00, IJ = 6'h02, IADDI = 6'h08.
- IORI = 6'h0D, ILW = 6'h23, ISW = 6'h2B.
REQ-021 The package SHALL also define the default data width (32) and opcode width (6).
REQ-022 One sub-module, alu_b_sel, SHALL hold the purely combinational select and valid decode. The top level SHALL hold only the output/valid register with reset and stall.

Verification
REQ-023 Reset then E_valB=35, E_op=IROP -> next cycle e_aluB=35, valid=1.
REQ-024 E_op=IJ, E_valB=77 -> e_aluB=0, valid=1; then E_op=IORI -> e_aluB=77.
REQ-025 E_valB=88 with E_op=ISW, then ILW, then IJ on consecutive cycles -> outputs 88, 88, 0, each one cycle after its input.
REQ-026 E_op=6'h3F, E_valB=32'hFFFFFFFF -> e_aluB=0, valid=0.
REQ-027 Hold and reset:
- Load 32'hDEADBEEF with IADDI, then raise stall for 3 cycles while changing the inputs -> output holds 32'hDEADBEEF.
- Assert rst while stall=1 -> e_aluB=0, valid=0.
